// File: rtl/ppm_frame_sequencer.sv
// ppm_frame_sequencer: frames decoded PPM bytes between SOF and EOF, tags the
// final byte of each frame through a one-entry pending register, buffers
// {last, data} in a small valid/ready FIFO and reports per-frame status.
module ppm_frame_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BYTES  = 256,
    parameter int TIMEOUT    = 1024,
    parameter int LEN_W      = 9
) (
    input  logic             clk16,
    input  logic             rst_n,
    input  logic             sof_rcv,
    input  logic             eof_rcv,
    input  logic             byte_vld,
    input  logic [7:0]       byte_data,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [LEN_W-1:0] frame_len,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_BYTES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_FLUSH} state_t;
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_FIFO = 2'b01,
        ERR_LEN  = 2'b10,
        ERR_TMO  = 2'b11
    } err_t;

    state_t             state;
    err_t               close_code;
    logic               pend_vld;
    logic [7:0]         pend_data;
    logic [LEN_W-1:0]   byte_cnt;
    logic [TMR_W-1:0]   timer;

    logic [8:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               pop;
    logic               accept;
    logic               flush_go;
    logic               push;
    logic               push_last;

    // "Full" is judged on the registered count, before any same-cycle pop.
    assign full    = (count == FULL_CNT);
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr][7:0];
    assign m_last  = mem[rd_ptr][8];
    assign pop     = m_valid && m_ready;
    assign busy    = (state != ST_IDLE) || (count != '0);

    // Decide whether the pending byte moves into the FIFO this cycle, and how it is tagged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        push      = 1'b0;
        push_last = 1'b0;
        accept    = (state == ST_RECV) && byte_vld && (!pend_vld || !full) && (byte_cnt < MAX_CNT);
        flush_go  = (state == ST_FLUSH) && (!pend_vld || !full);
        if (accept && pend_vld) begin
            push = 1'b1;
        end
        if (flush_go && pend_vld) begin
            push      = 1'b1;
            push_last = 1'b1;
        end
    end

    // FIFO payload storage; only the pointers and count need a defined reset value.
    always_ff @(posedge clk16) begin
        // NOTE: the storage array is deliberately not reset; m_valid gates it, so stale contents are never consumed.
        if (push) begin
            mem[wr_ptr] <= {push_last, pend_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame FSM: accepts bytes, detects close conditions and emits registered status.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            close_code <= ERR_NONE;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            byte_cnt   <= '0;
            timer      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'b00;
            frame_len  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sof_rcv) begin
                        state      <= ST_RECV;
                        byte_cnt   <= '0;
                        timer      <= '0;
                        close_code <= ERR_NONE;
                    end
                end
                ST_RECV: begin
                    if (byte_vld && pend_vld && full) begin
                        close_code <= ERR_FIFO;
                        state      <= ST_FLUSH;
                    end else if (byte_vld && byte_cnt == MAX_CNT) begin
                        close_code <= ERR_LEN;
                        state      <= ST_FLUSH;
                    end else begin
                        if (accept) begin
                            pend_vld  <= 1'b1;
                            pend_data <= byte_data;
                            byte_cnt  <= byte_cnt + LEN_W'(1);
                            timer     <= '0;
                        end
                        if (eof_rcv) begin
                            close_code <= ERR_NONE;
                            state      <= ST_FLUSH;
                        end else if (!byte_vld) begin
                            if (timer == TMR_LAST) begin
                                close_code <= ERR_TMO;
                                state      <= ST_FLUSH;
                            end else begin
                                timer <= timer + TMR_W'(1);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_go) begin
                        pend_vld   <= 1'b0;
                        frame_len  <= byte_cnt;
                        err_code   <= close_code;
                        frame_done <= (close_code == ERR_NONE);
                        frame_err  <= (close_code != ERR_NONE);
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// Directed bench for ppm_frame_sequencer. Two instances share the stimulus:
// dut_a (MAX_BYTES=8) covers the main, overflow and timeout cases, dut_b
// (MAX_BYTES=4) covers the length limit. Both use FIFO_DEPTH=4, TIMEOUT=16.
module tb_ppm_frame_sequencer;

    logic       clk16 = 1'b0;
    logic       rst_n;
    logic       sof_rcv, eof_rcv, byte_vld, m_ready;
    logic [7:0] byte_data;

    logic       a_m_valid, a_m_last, a_frame_done, a_frame_err, a_busy;
    logic [7:0] a_m_data;
    logic [1:0] a_err_code;
    logic [8:0] a_frame_len;
    logic       b_m_valid, b_m_last, b_frame_done, b_frame_err, b_busy;
    logic [7:0] b_m_data;
    logic [1:0] b_err_code;
    logic [8:0] b_frame_len;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  a_q[$];
    logic [8:0]  b_q[$];
    logic [12:0] a_ev[$];
    logic [12:0] b_ev[$];
    logic [8:0]  exp_q[$];

    always #5 clk16 = ~clk16;

    ppm_frame_sequencer #(.FIFO_DEPTH(4), .MAX_BYTES(8), .TIMEOUT(16), .LEN_W(9)) dut_a (
        .clk16(clk16), .rst_n(rst_n), .sof_rcv(sof_rcv), .eof_rcv(eof_rcv),
        .byte_vld(byte_vld), .byte_data(byte_data), .m_valid(a_m_valid),
        .m_data(a_m_data), .m_last(a_m_last), .m_ready(m_ready),
        .frame_done(a_frame_done), .frame_err(a_frame_err), .err_code(a_err_code),
        .frame_len(a_frame_len), .busy(a_busy)
    );

    ppm_frame_sequencer #(.FIFO_DEPTH(4), .MAX_BYTES(4), .TIMEOUT(16), .LEN_W(9)) dut_b (
        .clk16(clk16), .rst_n(rst_n), .sof_rcv(sof_rcv), .eof_rcv(eof_rcv),
        .byte_vld(byte_vld), .byte_data(byte_data), .m_valid(b_m_valid),
        .m_data(b_m_data), .m_last(b_m_last), .m_ready(m_ready),
        .frame_done(b_frame_done), .frame_err(b_frame_err), .err_code(b_err_code),
        .frame_len(b_frame_len), .busy(b_busy)
    );

    // Record accepted output beats and status pulses, sampled mid-cycle.
    always @(negedge clk16) begin
        if (a_m_valid && m_ready) a_q.push_back({a_m_last, a_m_data});
        if (b_m_valid && m_ready) b_q.push_back({b_m_last, b_m_data});
        if (a_frame_done || a_frame_err) a_ev.push_back({a_frame_done, a_frame_err, a_err_code, a_frame_len});
        if (b_frame_done || b_frame_err) b_ev.push_back({b_frame_done, b_frame_err, b_err_code, b_frame_len});
    end

    function automatic logic [12:0] ev(input logic d, input logic e, input logic [1:0] c, input logic [8:0] l);
        return {d, e, c, l};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk16);
        #1;
    endtask

    task automatic send_sof();
        sof_rcv = 1'b1; tick(); sof_rcv = 1'b0;
    endtask

    task automatic send_eof();
        eof_rcv = 1'b1; tick(); eof_rcv = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic with_eof);
        byte_vld = 1'b1; byte_data = d; eof_rcv = with_eof;
        tick();
        byte_vld = 1'b0; eof_rcv = 1'b0;
    endtask

    task automatic clear_logs();
        a_q.delete(); b_q.delete(); a_ev.delete(); b_ev.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((a_busy || b_busy) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(a_busy || b_busy), 0);
        tick();
        tick();
    endtask

    task automatic check_stream(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic check_event(input string tag, input logic [12:0] got[$], input logic [12:0] exp);
        check({tag, "_pulses"}, got.size(), 1);
        if (got.size() > 0) check({tag, "_status"}, 32'(got[0]), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sof_rcv = 1'b0; eof_rcv = 1'b0; byte_vld = 1'b0;
        byte_data = 8'h00; m_ready = 1'b1;
        tick(); tick();
        check("rst_m_valid", 32'(a_m_valid), 0);
        check("rst_pulses", 32'({a_frame_done, a_frame_err}), 0);
        check("rst_err_code", 32'(a_err_code), 0);
        check("rst_frame_len", 32'(a_frame_len), 0);
        check("rst_busy", 32'(a_busy), 0);
        rst_n = 1'b1;
        tick();

        // Normal frame; first byte is held back until the next one arrives.
        clear_logs();
        send_sof();
        send_byte(8'hA5, 1'b0);
        check("lat_hold0", 32'(a_m_valid), 0);
        tick();
        check("lat_hold1", 32'(a_m_valid), 0);
        send_byte(8'h3C, 1'b0);
        check("lat_release", 32'(a_m_valid), 1);
        send_byte(8'hFF, 1'b0);
        send_eof();
        wait_idle("normal");
        exp_q = '{9'h0A5, 9'h03C, 9'h1FF};
        check_stream("normal", a_q, exp_q);
        check_event("normal", a_ev, ev(1'b1, 1'b0, 2'b00, 9'd3));

        // Empty frame.
        clear_logs();
        send_sof();
        send_eof();
        wait_idle("empty");
        check("empty_no_data", a_q.size(), 0);
        check_event("empty", a_ev, ev(1'b1, 1'b0, 2'b00, 9'd0));

        // Backpressure overflow: 01..04 in FIFO, 05 pending, 06 dropped.
        clear_logs();
        m_ready = 1'b0;
        send_sof();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        tick(); tick(); tick();
        check("ovf_valid", 32'(a_m_valid), 1);
        check("ovf_head", 32'({a_m_last, a_m_data}), 32'h001);
        check("ovf_no_pulse_yet", a_ev.size(), 0);
        tick(); tick();
        check("ovf_head_stable", 32'({a_m_last, a_m_data}), 32'h001);
        m_ready = 1'b1;
        wait_idle("ovf");
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h105};
        check_stream("ovf", a_q, exp_q);
        check_event("ovf", a_ev, ev(1'b0, 1'b1, 2'b01, 9'd5));

        // Timeout: 16 idle cycles after the byte closes the frame with an error.
        clear_logs();
        send_sof();
        send_byte(8'h11, 1'b0);
        repeat (15) tick();
        check("tmo_not_yet", a_ev.size(), 0);
        tick();
        wait_idle("tmo");
        exp_q = '{9'h111};
        check_stream("tmo", a_q, exp_q);
        check_event("tmo", a_ev, ev(1'b0, 1'b1, 2'b11, 9'd1));
        check("tmo_err_held", 32'(a_err_code), 32'h3);

        // 15 idle cycles then EOF is still a normal close.
        clear_logs();
        send_sof();
        send_byte(8'h11, 1'b0);
        repeat (15) tick();
        send_eof();
        wait_idle("tmo_edge");
        exp_q = '{9'h111};
        check_stream("tmo_edge", a_q, exp_q);
        check_event("tmo_edge", a_ev, ev(1'b1, 1'b0, 2'b00, 9'd1));

        // Length limit on dut_b (MAX_BYTES=4): byte 14 dropped.
        clear_logs();
        send_sof();
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b0);
        send_eof();
        wait_idle("len");
        exp_q = '{9'h010, 9'h011, 9'h012, 9'h113};
        check_stream("len", b_q, exp_q);
        check_event("len", b_ev, ev(1'b0, 1'b1, 2'b10, 9'd4));
        check("len_err_held", 32'(b_err_code), 32'h2);

        // Byte and EOF in the same cycle: that byte is the last one.
        clear_logs();
        send_sof();
        send_byte(8'h7D, 1'b0);
        send_byte(8'h7E, 1'b1);
        wait_idle("vld_eof");
        exp_q = '{9'h07D, 9'h17E};
        check_stream("vld_eof", a_q, exp_q);
        check_event("vld_eof", a_ev, ev(1'b1, 1'b0, 2'b00, 9'd2));

        // Stray byte and EOF while idle produce nothing.
        clear_logs();
        send_byte(8'h99, 1'b1);
        send_eof();
        send_byte(8'h98, 1'b0);
        tick(); tick(); tick();
        check("stray_busy", 32'(a_busy), 0);
        check("stray_data", a_q.size(), 0);
        check("stray_pulses", a_ev.size(), 0);

        // Reset mid-frame with three bytes in the FIFO and one pending.
        m_ready = 1'b0;
        send_sof();
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b0);
        check("prerst_valid", 32'(a_m_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(a_m_valid), 0);
        check("midrst_busy", 32'(a_busy), 0);
        check("midrst_len", 32'(a_frame_len), 0);
        check("midrst_err", 32'(a_err_code), 0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        clear_logs();
        send_sof();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_eof();
        wait_idle("postrst");
        exp_q = '{9'h055, 9'h166};
        check_stream("postrst", a_q, exp_q);
        check_event("postrst", a_ev, ev(1'b1, 1'b0, 2'b00, 9'd2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
